// File: rtl/lc3b_types.sv
// lc3b_types: shared types for the LC-3b memory hierarchy.
//   lc3b_word   - 16-bit address/data word
//   lc3b_chunk  - 128-bit cache line
//   arb_state_t - memory arbiter FSM states
//   idx_width() - bits needed to index n clients (minimum 1)
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_chunk;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin / fixed-priority selector.
//   req        - per-client request vector
//   ptr        - index where the round-robin search starts
//   fixed_mode - 1: search always starts at index 0 (lowest index wins)
//   valid      - at least one request present
//   winner     - one-hot winner (0 when no request)
//   winner_idx - binary index of the winner (0 when no request)
// The request vector is rotated so the start index lands at bit 0, the
// lowest set bit is found, and the result is rotated back by adding the
// start index modulo N.
module rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          fixed_mode,
    output logic          valid,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx
);

    logic [IW-1:0]  start;
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW-1:0]  rot_idx;
    logic           found;
    logic [IW:0]    sum;

    always_comb begin
        start   = fixed_mode ? '0 : ptr;
        // Shifting a doubled copy right by start is a rotate for any N.
        doubled = {req, req} >> start;
        rotated = doubled[N-1:0];

        // Descending scan: the last hit written is the lowest set bit.
        found   = 1'b0;
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                rot_idx = IW'(i);
                found   = 1'b1;
            end
        end

        sum = {1'b0, rot_idx} + {1'b0, start};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end

        valid      = found;
        winner_idx = found ? sum[IW-1:0] : '0;
        winner     = '0;
        if (found) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: shares one physical-memory port among NUM_PORTS clients.
//   clk, reset       - clock, asynchronous active-high reset
//   port_read/write  - per-client held requests (until port_resp)
//   port_address     - per-client address
//   port_wdata       - per-client write line
//   port_resp        - one-hot completion pulse to the granted client
//   port_rdata       - pmem_rdata broadcast to all clients
//   pmem_read/write  - registered memory command of the granted client
//   pmem_address     - address of the granted client (port 0 when idle)
//   pmem_wdata       - write line of the granted client (port 0 when idle)
//   pmem_rdata       - memory read line
//   pmem_resp        - memory completion pulse
//   grant            - registered one-hot grant, 0 when idle
// Handshake: a client raises port_read or port_write and holds it, with
// its address/data stable, until it sees its port_resp bit; it must drop
// the request in the cycle after port_resp. The grant is held from the
// cycle after selection until pmem_resp, regardless of the request.
module mem_arbiter_rr
    import lc3b_types::*;
#(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_WIDTH     = $bits(lc3b_word),
    parameter int unsigned DATA_WIDTH     = $bits(lc3b_chunk),
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 port_read,
    input  logic [NUM_PORTS-1:0]                 port_write,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_wdata,
    output logic [NUM_PORTS-1:0]                 port_resp,
    output logic [DATA_WIDTH-1:0]                port_rdata,
    output logic                                 pmem_read,
    output logic                                 pmem_write,
    output logic [ADDR_WIDTH-1:0]                pmem_address,
    output logic [DATA_WIDTH-1:0]                pmem_wdata,
    input  logic [DATA_WIDTH-1:0]                pmem_rdata,
    input  logic                                 pmem_resp,
    output logic [NUM_PORTS-1:0]                 grant
);

    localparam int unsigned IW = idx_width(NUM_PORTS);

    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q;
    logic [IW-1:0]        grant_idx_q;
    logic [IW-1:0]        ptr_q;
    logic                 rd_lat_q, wr_lat_q;

    logic [NUM_PORTS-1:0] req;
    logic                 pick_valid;
    logic [NUM_PORTS-1:0] pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 done;

    assign req  = port_read | port_write;
    assign done = (state_q == BUSY) && pmem_resp;

    rr_picker #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .fixed_mode (FIXED_PRIORITY),
        .valid      (pick_valid),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = BUSY;
            BUSY:    if (pmem_resp)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            rd_lat_q    <= 1'b0;
            wr_lat_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            if (pick_valid) begin
                grant_q     <= pick_onehot;
                grant_idx_q <= pick_idx;
                rd_lat_q    <= port_read[pick_idx];
                wr_lat_q    <= port_write[pick_idx];
            end
        end else if (pmem_resp) begin
            // Index returns to 0 so the idle muxes present port 0.
            grant_q     <= '0;
            grant_idx_q <= '0;
            rd_lat_q    <= 1'b0;
            wr_lat_q    <= 1'b0;
            if (!FIXED_PRIORITY) begin
                ptr_q <= (grant_idx_q == IW'(NUM_PORTS - 1)) ? '0 : grant_idx_q + IW'(1);
            end
        end
    end

    assign grant        = grant_q;
    assign pmem_read    = rd_lat_q;
    assign pmem_write   = wr_lat_q;
    assign pmem_address = port_address[grant_idx_q];
    assign pmem_wdata   = port_wdata[grant_idx_q];
    assign port_rdata   = pmem_rdata;
    assign port_resp    = done ? grant_q : '0;

    // A client may not request a read and a write in the same cycle.
    assert property (@(posedge clk) disable iff (reset) !(|(port_read & port_write)));

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 128;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N-1:0]         port_read, port_write;
    logic [N-1:0][AW-1:0] port_address;
    logic [N-1:0][DW-1:0] port_wdata;
    logic [DW-1:0]        pmem_rdata;
    logic                 pmem_resp;

    logic [N-1:0]  r_port_resp, r_grant, f_port_resp, f_grant;
    logic [DW-1:0] r_port_rdata, r_pmem_wdata, f_port_rdata, f_pmem_wdata;
    logic          r_pmem_read, r_pmem_write, f_pmem_read, f_pmem_write;
    logic [AW-1:0] r_pmem_address, f_pmem_address;

    int errors = 0;
    int checks = 0;

    mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) u_rr (
        .clk(clk), .reset(reset), .port_read(port_read), .port_write(port_write),
        .port_address(port_address), .port_wdata(port_wdata), .port_resp(r_port_resp),
        .port_rdata(r_port_rdata), .pmem_read(r_pmem_read), .pmem_write(r_pmem_write),
        .pmem_address(r_pmem_address), .pmem_wdata(r_pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .grant(r_grant)
    );

    mem_arbiter_rr #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) u_fx (
        .clk(clk), .reset(reset), .port_read(port_read), .port_write(port_write),
        .port_address(port_address), .port_wdata(port_wdata), .port_resp(f_port_resp),
        .port_rdata(f_port_rdata), .pmem_read(f_pmem_read), .pmem_write(f_pmem_write),
        .pmem_address(f_pmem_address), .pmem_wdata(f_pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .grant(f_grant)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        port_read    = '0;
        port_write   = '0;
        port_address = '0;
        port_wdata   = '0;
        pmem_rdata   = '0;
        pmem_resp    = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        settle();
        checks++; if (r_grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", r_grant); end
        checks++; if (r_pmem_read !== 1'b0 || r_pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_cmd got=%b%b exp=00", r_pmem_read, r_pmem_write); end
        checks++; if (f_grant !== '0) begin errors++; $display("FAIL reset_fx_grant got=%b exp=0", f_grant); end
        // Requests during reset must not be granted.
        port_read = '1;
        step();
        settle();
        checks++; if (r_grant !== '0) begin errors++; $display("FAIL reset_hold_grant got=%b exp=0", r_grant); end
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_single_read();
        apply_reset();
        port_read[0]    = 1'b1;
        port_address[0] = 16'h1230;
        settle();
        checks++; if (r_pmem_read !== 1'b0) begin errors++; $display("FAIL rd_early got=%b exp=0", r_pmem_read); end
        step();
        settle();
        checks++; if (r_grant !== 4'b0001) begin errors++; $display("FAIL rd_grant got=%b exp=0001", r_grant); end
        checks++; if (r_pmem_read !== 1'b1 || r_pmem_write !== 1'b0) begin errors++; $display("FAIL rd_cmd got=%b%b exp=10", r_pmem_read, r_pmem_write); end
        checks++; if (r_pmem_address !== 16'h1230) begin errors++; $display("FAIL rd_addr got=%h exp=1230", r_pmem_address); end
        repeat (3) begin
            step();
            settle();
            checks++; if (r_port_resp !== '0 || r_pmem_read !== 1'b1) begin errors++; $display("FAIL rd_wait resp=%b rd=%b exp resp=0 rd=1", r_port_resp, r_pmem_read); end
        end
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = {16{8'hA5}};
        settle();
        checks++; if (r_port_resp !== 4'b0001) begin errors++; $display("FAIL rd_resp got=%b exp=0001", r_port_resp); end
        checks++; if (r_port_rdata !== {16{8'hA5}}) begin errors++; $display("FAIL rd_rdata got=%h exp=a5..a5", r_port_rdata); end
        step();
        pmem_resp = 1'b0;
        port_read = '0;
        settle();
        checks++; if (r_grant !== '0 || r_pmem_read !== 1'b0) begin errors++; $display("FAIL rd_idle grant=%b rd=%b exp 0 0", r_grant, r_pmem_read); end
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        port_read = 4'b0010;
        step();
        settle();
        checks++; if (r_grant !== 4'b0010 || r_pmem_read !== 1'b1) begin errors++; $display("FAIL rmb_setup grant=%b rd=%b exp 0010 1", r_grant, r_pmem_read); end
        reset     = 1'b1;
        pmem_resp = 1'b1;
        #1;
        checks++; if (r_pmem_read !== 1'b0) begin errors++; $display("FAIL rmb_read got=%b exp=0", r_pmem_read); end
        checks++; if (r_grant !== '0) begin errors++; $display("FAIL rmb_grant got=%b exp=0", r_grant); end
        checks++; if (r_port_resp !== '0) begin errors++; $display("FAIL rmb_resp got=%b exp=0", r_port_resp); end
        step();
        reset     = 1'b0;
        pmem_resp = 1'b0;
        port_read = 4'b0011;
        step();
        settle();
        checks++; if (r_grant !== 4'b0001) begin errors++; $display("FAIL rmb_after got=%b exp=0001", r_grant); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        int d;
        apply_reset();
        for (int i = 0; i < N; i++) port_address[i] = AW'(16'h0100 * (i + 1));
        port_read = '1;
        step();
        for (int g = 0; g < 5; g++) begin
            int w;
            w = g % N;
            settle();
            checks++; if (r_grant !== onehot(w)) begin errors++; $display("FAIL rr_order g=%0d got=%b exp=%b", g, r_grant, onehot(w)); end
            checks++; if (r_pmem_address !== AW'(16'h0100 * (w + 1))) begin errors++; $display("FAIL rr_addr g=%0d got=%h exp=%h", g, r_pmem_address, 16'h0100 * (w + 1)); end
            d = $urandom_range(1, 4);
            repeat (d) step();
            pmem_resp = 1'b1;
            settle();
            checks++; if (r_port_resp !== onehot(w)) begin errors++; $display("FAIL rr_resp g=%0d got=%b exp=%b", g, r_port_resp, onehot(w)); end
            step();
            pmem_resp    = 1'b0;
            port_read[w] = 1'b0;
            settle();
            checks++; if (r_grant !== '0) begin errors++; $display("FAIL rr_gap g=%0d got=%b exp=0", g, r_grant); end
            step();
            port_read[w] = 1'b1;
        end
        clear_inputs();
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        port_read       = 4'b0101;
        port_address[0] = 16'h1000;
        port_address[2] = 16'h3000;
        step();
        for (int g = 0; g < 4; g++) begin
            settle();
            checks++; if (f_grant !== 4'b0001) begin errors++; $display("FAIL fx_grant g=%0d got=%b exp=0001", g, f_grant); end
            checks++; if (f_pmem_address !== 16'h1000) begin errors++; $display("FAIL fx_addr g=%0d got=%h exp=1000", g, f_pmem_address); end
            repeat ($urandom_range(1, 3)) step();
            pmem_resp = 1'b1;
            settle();
            checks++; if (f_port_resp !== 4'b0001) begin errors++; $display("FAIL fx_resp g=%0d got=%b exp=0001", g, f_port_resp); end
            step();
            pmem_resp = 1'b0;
            settle();
            checks++; if (f_grant !== '0) begin errors++; $display("FAIL fx_gap g=%0d got=%b exp=0", g, f_grant); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_write_while_waiting();
        apply_reset();
        port_write[1]   = 1'b1;
        port_address[1] = 16'h4000;
        port_wdata[1]   = {8{16'hDEAD}};
        port_address[0] = 16'h0100;
        step();
        port_read[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (r_grant !== 4'b0010) begin errors++; $display("FAIL wr_grant c=%0d got=%b exp=0010", c, r_grant); end
            checks++; if (r_pmem_write !== 1'b1 || r_pmem_read !== 1'b0) begin errors++; $display("FAIL wr_cmd c=%0d got=%b%b exp=01", c, r_pmem_read, r_pmem_write); end
            checks++; if (r_pmem_address !== 16'h4000) begin errors++; $display("FAIL wr_addr c=%0d got=%h exp=4000", c, r_pmem_address); end
            checks++; if (r_pmem_wdata !== {8{16'hDEAD}}) begin errors++; $display("FAIL wr_data c=%0d got=%h exp=dead..", c, r_pmem_wdata); end
            step();
        end
        pmem_resp = 1'b1;
        settle();
        checks++; if (r_port_resp !== 4'b0010) begin errors++; $display("FAIL wr_resp got=%b exp=0010", r_port_resp); end
        step();
        pmem_resp     = 1'b0;
        port_write[1] = 1'b0;
        step();
        settle();
        checks++; if (r_grant !== 4'b0001 || r_pmem_read !== 1'b1) begin errors++; $display("FAIL wr_next grant=%b rd=%b exp 0001 1", r_grant, r_pmem_read); end
        checks++; if (r_pmem_address !== 16'h0100) begin errors++; $display("FAIL wr_next_addr got=%h exp=0100", r_pmem_address); end
        clear_inputs();
    endtask

    task automatic test_stray_inputs();
        apply_reset();
        pmem_resp = 1'b1;
        settle();
        checks++; if (r_port_resp !== '0) begin errors++; $display("FAIL stray_resp got=%b exp=0", r_port_resp); end
        step();
        pmem_resp = 1'b0;
        settle();
        checks++; if (r_grant !== '0) begin errors++; $display("FAIL stray_state got=%b exp=0", r_grant); end
        port_read[2]    = 1'b1;
        port_address[2] = 16'h2222;
        step();
        port_read[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (r_pmem_read !== 1'b1 || r_grant !== 4'b0100) begin errors++; $display("FAIL drop_hold c=%0d rd=%b grant=%b exp 1 0100", c, r_pmem_read, r_grant); end
            step();
        end
        pmem_resp = 1'b1;
        settle();
        checks++; if (r_port_resp !== 4'b0100) begin errors++; $display("FAIL drop_resp got=%b exp=0100", r_port_resp); end
        step();
        pmem_resp = 1'b0;
        settle();
        checks++; if (r_pmem_read !== 1'b0) begin errors++; $display("FAIL drop_end got=%b exp=0", r_pmem_read); end
        clear_inputs();
    endtask

    // Random traffic against a transaction-level model of the round-robin
    // arbiter: pending clients, a pointer, and the client currently served.
    task automatic test_random();
        bit            pend[N];
        bit            is_rd[N];
        bit            cool[N];
        logic [AW-1:0] addr[N];
        logic [DW-1:0] wd[N];
        int            m_ptr, m_cur;
        bit            m_busy, m_rd, resp, found;
        logic [N-1:0]  eg;
        apply_reset();
        m_ptr = 0; m_cur = 0; m_busy = 0; m_rd = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; is_rd[i] = 0; cool[i] = 0; addr[i] = '0; wd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (cool[i]) cool[i] = 0;
                else if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i]  = 1;
                    is_rd[i] = 1'($urandom_range(0, 1));
                    addr[i]  = AW'($urandom);
                    wd[i]    = {$urandom, $urandom, $urandom, $urandom};
                end
                port_read[i]    = pend[i] && is_rd[i];
                port_write[i]   = pend[i] && !is_rd[i];
                port_address[i] = addr[i];
                port_wdata[i]   = wd[i];
            end
            resp       = m_busy && ($urandom_range(0, 2) == 0);
            pmem_resp  = resp;
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            settle();
            eg = '0;
            if (m_busy) eg[m_cur] = 1'b1;
            checks++; if (r_grant !== eg) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, r_grant, eg); end
            checks++; if (r_pmem_read !== (m_busy && m_rd) || r_pmem_write !== (m_busy && !m_rd)) begin errors++; $display("FAIL rnd_cmd cyc=%0d got=%b%b exp=%b%b", cyc, r_pmem_read, r_pmem_write, m_busy && m_rd, m_busy && !m_rd); end
            checks++; if (r_port_resp !== (resp ? eg : '0)) begin errors++; $display("FAIL rnd_resp cyc=%0d got=%b exp=%b", cyc, r_port_resp, resp ? eg : '0); end
            checks++; if (r_port_rdata !== pmem_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, r_port_rdata, pmem_rdata); end
            if (m_busy) begin
                checks++; if (r_pmem_address !== addr[m_cur]) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, r_pmem_address, addr[m_cur]); end
                if (!m_rd) begin
                    checks++; if (r_pmem_wdata !== wd[m_cur]) begin errors++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, r_pmem_wdata, wd[m_cur]); end
                end
            end
            if (m_busy) begin
                if (resp) begin
                    pend[m_cur] = 0;
                    cool[m_cur] = 1;
                    m_ptr       = (m_cur + 1) % N;
                    m_busy      = 0;
                end
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!found && pend[j]) begin
                        found = 1;
                        m_cur = j;
                    end
                end
                if (found) begin
                    m_busy = 1;
                    m_rd   = is_rd[m_cur];
                end
            end
            step();
        end
        clear_inputs();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_reset_mid_busy();
        test_round_robin();
        test_fixed_priority();
        test_write_while_waiting();
        test_stray_inputs();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
